// File: rtl/sprite_pkg.sv
// sprite_pkg: shared constants and FSM state type for the sprite line scanner
package sprite_pkg;
    localparam logic [1:0] OFS_ATTR = 2'd0;
    localparam logic [1:0] OFS_CODE = 2'd1;
    localparam logic [1:0] OFS_Y = 2'd2;
    localparam logic [1:0] OFS_X = 2'd3;
    localparam int ATTR_BIG_BIT = 7;
    localparam logic [5:0] H_SMALL = 6'd16;
    localparam logic [5:0] H_BIG = 6'd32;
    typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, EVAL, EMIT, FIN} state_t;
endpackage

// File: rtl/sprite_vhit.sv
// sprite_vhit: combinational vertical overlap test of one sprite against a line
module sprite_vhit
    import sprite_pkg::*;
(
    input  logic [7:0] i_line,
    input  logic [7:0] i_y,
    input  logic       i_big,
    output logic       o_hit,
    output logic [4:0] o_row
);
    logic [7:0] w_diff;
    assign w_diff = i_line - i_y;
    assign o_hit = w_diff < {2'b00, i_big ? H_BIG : H_SMALL};
    assign o_row = w_diff[4:0];
endmodule

// File: rtl/sprite_line_scan.sv
// sprite_line_scan: walks the sprite attribute table per line and emits overlapping sprites
module sprite_line_scan
    import sprite_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int BASE_ADDR = 0,
    parameter int SPR_COUNT = 24,
    parameter int MAX_HITS = 8
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_line,
    output logic [ADDR_W-1:0] o_ram_addr,
    input  logic [7:0]        i_ram_q,
    output logic              o_spr_valid,
    input  logic              i_spr_ready,
    output logic [7:0]        o_spr_attr,
    output logic [7:0]        o_spr_code,
    output logic [7:0]        o_spr_x,
    output logic [4:0]        o_spr_row,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_overflow
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int HIT_W = $clog2(MAX_HITS + 1);
    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [HIT_W-1:0] r_hits;
    logic [7:0]       r_line, r_attr, r_code, r_y;
    logic [7:0]       r_spr_attr, r_spr_code, r_spr_x;
    logic [4:0]       r_spr_row;
    logic             r_spr_valid, r_overflow;
    logic [1:0]       w_ofs;
    logic             w_last, w_hit;
    logic [4:0]       w_row;
    always_comb begin
        w_ofs = r_state == RD1 ? OFS_CODE : r_state == RD2 ? OFS_Y : r_state == RD3 ? OFS_X : OFS_ATTR;
    end
    assign o_ram_addr = ADDR_W'(BASE_ADDR) + {r_idx, 2'b00} + ADDR_W'(w_ofs);
    assign w_last = r_idx == IDX_W'(SPR_COUNT - 1);
    sprite_vhit u_vhit (
        .i_line(r_line),
        .i_y   (r_y),
        .i_big (r_attr[ATTR_BIG_BIT]),
        .o_hit (w_hit),
        .o_row (w_row)
    );
    // x is not registered separately: it arrives on i_ram_q during EVAL
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_idx <= '0;
            r_hits <= '0;
            r_line <= '0;
            r_attr <= '0;
            r_code <= '0;
            r_y <= '0;
            r_spr_attr <= '0;
            r_spr_code <= '0;
            r_spr_x <= '0;
            r_spr_row <= '0;
            r_spr_valid <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_line <= i_line;
                    r_overflow <= 1'b0;
                    r_hits <= '0;
                    r_idx <= '0;
                    r_state <= RD0;
                end
                RD0: r_state <= RD1;
                RD1: begin
                    r_attr <= i_ram_q;
                    r_state <= RD2;
                end
                RD2: begin
                    r_code <= i_ram_q;
                    r_state <= RD3;
                end
                RD3: begin
                    r_y <= i_ram_q;
                    r_state <= EVAL;
                end
                EVAL: if (w_hit && r_hits < HIT_W'(MAX_HITS)) begin
                    r_spr_attr <= r_attr;
                    r_spr_code <= r_code;
                    r_spr_x <= i_ram_q;
                    r_spr_row <= w_row;
                    r_spr_valid <= 1'b1;
                    r_state <= EMIT;
                end else if (w_hit) begin
                    r_overflow <= 1'b1;
                    r_state <= FIN;
                end else begin
                    r_idx <= r_idx + 1'b1;
                    r_state <= w_last ? FIN : RD0;
                end
                EMIT: if (i_spr_ready) begin
                    r_spr_valid <= 1'b0;
                    r_hits <= r_hits + 1'b1;
                    r_idx <= r_idx + 1'b1;
                    r_state <= w_last ? FIN : RD0;
                end
                default: begin
                    r_idx <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign o_spr_valid = r_spr_valid;
    assign o_spr_attr = r_spr_attr;
    assign o_spr_code = r_spr_code;
    assign o_spr_x = r_spr_x;
    assign o_spr_row = r_spr_row;
    assign o_overflow = r_overflow;
    assign o_busy = r_state != IDLE && r_state != FIN;
    assign o_done = r_state == FIN;
endmodule

// File: tb/tb_sprite_line_scan.sv
// tb_sprite_line_scan: randomized and directed checks against a table-level reference model
module tb_sprite_line_scan;
    typedef struct packed {
        logic [7:0] attr;
        logic [7:0] code;
        logic [7:0] x;
        logic [4:0] row;
    } rec_t;
    localparam int NSPR = 24;
    logic       clk = 1'b0;
    logic       rst, start, ready;
    logic [7:0] line_in, ram_q;
    logic [6:0] ram_addr;
    logic       spr_valid, busy, done, overflow;
    logic [7:0] spr_attr, spr_code, spr_x;
    logic [4:0] spr_row;
    logic [7:0] mem [0:127];
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    always @(posedge clk) ram_q <= mem[ram_addr];
    sprite_line_scan dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_line(line_in),
        .o_ram_addr(ram_addr), .i_ram_q(ram_q), .o_spr_valid(spr_valid), .i_spr_ready(ready),
        .o_spr_attr(spr_attr), .o_spr_code(spr_code), .o_spr_x(spr_x), .o_spr_row(spr_row),
        .o_busy(busy), .o_done(done), .o_overflow(overflow)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic set_spr(input int n, input logic [7:0] a, c, y, x);
        mem[4*n] = a;
        mem[4*n+1] = c;
        mem[4*n+2] = y;
        mem[4*n+3] = x;
    endtask
    task automatic clear_all();
        for (int n = 0; n < NSPR; n++) set_spr(n, 8'h00, 8'h00, 8'h80, 8'h00);
    endtask
    task automatic run_scan(input logic [7:0] line, input int stall, input int misuse_t);
        rec_t q[$];
        rec_t cur, snap;
        logic ovf = 1'b0;
        logic seen = 1'b0;
        int last = NSPR - 1;
        int k = 0, w = 0, lat;
        for (int n = 0; n < NSPR; n++) begin
            logic [7:0] a = mem[4*n], d = line - mem[4*n+2];
            int h = a[7] ? 32 : 16;
            if (int'(d) < h) begin
                if (q.size() == 8) begin
                    ovf = 1'b1;
                    last = n;
                    break;
                end
                q.push_back({a, mem[4*n+1], mem[4*n+3], d[4:0]});
            end
        end
        lat = 5 * (last + 1) + 1 + q.size() * (stall + 1);
        @(negedge clk);
        start = 1'b1;
        line_in = line;
        ready = 1'b0;
        @(negedge clk);
        chk("ovf_clear", overflow, 1'b0);
        for (int t = 1; t <= 2000 && !seen; t++) begin
            if (t > 1) @(negedge clk);
            start = t == misuse_t;
            line_in = t == misuse_t ? ~line : line;
            if (done) begin
                seen = 1'b1;
                chk("done_lat", t, lat);
                chk("overflow", overflow, ovf);
                chk("rec_count", k, q.size());
                chk("busy_fin", busy, 1'b0);
            end else chk("busy", busy, 1'b1);
            ready = 1'b0;
            if (spr_valid) begin
                cur = {spr_attr, spr_code, spr_x, spr_row};
                if (k >= q.size()) chk("rec_extra", k + 1, q.size());
                else if (w == 0) begin
                    snap = cur;
                    chk("rec", cur, q[k]);
                end else chk("rec_stable", cur, snap);
                ready = w == stall;
                if (ready) begin
                    k++;
                    w = 0;
                end else w++;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1'b1);
        @(negedge clk);
        ready = 1'b0;
        chk("done_pulse", done, 1'b0);
        chk("overflow_hold", overflow, ovf);
    endtask
    initial begin
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        line_in = 8'h00;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        clear_all();
        repeat (3) @(negedge clk);
        chk("rst_valid", spr_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_addr", ram_addr, 7'd0);
        chk("rst_spr", {spr_attr, spr_code, spr_x, spr_row}, 29'd0);
        rst = 1'b0;
        run_scan(8'h10, 0, 0);
        set_spr(5, 8'h00, 8'h3A, 8'h20, 8'h55);
        run_scan(8'h2F, 0, 0);
        run_scan(8'h30, 0, 0);
        clear_all();
        set_spr(0, 8'h80, 8'h11, 8'hF0, 8'h22);
        run_scan(8'h0A, 0, 0);
        set_spr(0, 8'h00, 8'h11, 8'hF0, 8'h22);
        run_scan(8'h0A, 0, 0);
        clear_all();
        set_spr(0, 8'h00, 8'h01, 8'hF8, 8'h10);
        set_spr(9, 8'h80, 8'h02, 8'h00, 8'h20);
        set_spr(23, 8'h00, 8'h03, 8'h04, 8'h30);
        run_scan(8'h04, 0, 0);
        run_scan(8'h04, 7, 0);
        clear_all();
        for (int n = 0; n < 10; n++) set_spr(2 * n + 1, 8'(n), 8'(n + 8'h40), 8'h10, 8'(3 * n));
        run_scan(8'h10, 1, 0);
        run_scan(8'h10, 0, 37);
        run_scan(8'h90, 2, 60);
        clear_all();
        set_spr(0, 8'h00, 8'hAA, 8'h10, 8'hBB);
        @(negedge clk);
        start = 1'b1;
        line_in = 8'h10;
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < 20 && !spr_valid; t++) @(negedge clk);
        chk("emit_reached", spr_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_emit_valid", spr_valid, 1'b0);
        chk("rst_emit_busy", busy, 1'b0);
        chk("rst_emit_done", done, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", busy, 1'b0);
        for (int r = 0; r < 20; r++) begin
            logic [7:0] l = 8'($urandom);
            for (int n = 0; n < NSPR; n++)
                set_spr(n, 8'($urandom), 8'($urandom), l - 8'($urandom_range(0, 40)), 8'($urandom));
            run_scan(l, $urandom_range(0, 3), $urandom_range(0, 1) * $urandom_range(2, 100));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
